tlp_tx_source: RTL
==================

Name: tlp_tx_source

Overview:
- Transmit-side traffic source for the PCIe transaction-layer datapath.
- Drives the four ingress FIFO push/data ports from queued burst commands and honours each FIFO's almost_full backpressure.
- Keeps per-port sent-word counters with the same req/idx/valid readout protocol as the receive-side counters, so benches compare TX and RX totals directly.
- Sits upstream of the transaction layer; one engine per ingress FIFO.

Parameters:
- DW, 10, word width; data = {dest[1:0], payload[7:0]}.
- LW, 4, burst length width (max burst 15 words).
- CW, 5, counter width; each counter saturates at 2^CW-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  re-initialise: abort bursts, clear counters.
- cmd_valid  in  1  burst command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_port  in  2  target ingress FIFO, 0..3.
- cmd_dest  in  2  destination field placed in data[9:8].
- cmd_len  in  LW  number of words, 0..15.
- cmd_seed  in  8  payload of the first word.
- almost_full0..3  in  1 each  backpressure from ingress FIFO i.
- push_out0..3  out  1 each  push strobe to ingress FIFO i.
- data_out0..3  out  DW each  word to ingress FIFO i.
- busy  out  4  bit i high while engine i holds an unfinished burst.
- req  in  1  counter read request.
- idx  in  2  counter index for the read.
- contador  out  CW  counter read data.
- valid  out  1  contador valid.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) forces, on the next edge:
  - push_out* = 0, data_out* = 0, busy = 0, cmd_ready = 0, contador = 0, valid = 0.
  - FSM to RESET; all counters and engine registers to 0.
  - Reset dominates init, cmd and req.
- Global FSM:
  - RESET -> INIT on the first cycle with reset = 0.
  - INIT: held while init = 1; leaves when init = 0. In INIT, cmd_ready = 0, engines are cleared, counters are cleared.
  - INIT -> IDLE when init = 0.
  - IDLE <-> ACTIVE: ACTIVE when busy != 0, otherwise IDLE.
  - From IDLE or ACTIVE, init = 1 -> INIT. Any in-flight bursts are aborted, and push_out* = 0 from the next cycle.
- cmd_ready = (state is IDLE or ACTIVE) && !busy[cmd_port]. It is combinational on cmd_port from registered busy/state. This is the only combinational output.
- Command accept on cycle t:
  - Engine cmd_port loads rem = cmd_len, pay = cmd_seed, dst = cmd_dest.
  - busy[cmd_port] = 1 from t+1.
  - If cmd_len = 0, the command is accepted and dropped: busy stays 0 and no push occurs.
- Engine i, cycle t, with busy[i] = 1 and almost_full_i = 0:
  - At t+1: push_out_i = 1 and data_out_i = {dst, pay}.
  - pay increments mod 256; rem decrements.
  - On the push with rem = 1, busy[i] clears at t+1, the same edge as the last push.
- almost_full_i = 1 at cycle t means no push at t+1. The engine holds (state unchanged) and data_out_i keeps its last value.
- Latency: command accepted at t, first push at t+1 at the earliest. A full 15-word burst with no backpressure ends at t+15.
- Backpressure has 1-cycle response; the ingress FIFO almost_full threshold must leave at least 1 free slot.
- Engines are independent: different ports push in the same cycle, and a new command to an idle port is accepted while other ports are busy. A back-to-back command to the same port is accepted at the earliest on the cycle busy[i] is 0.
- Counter i increments on each push_out_i and saturates at 31 (no wrap).
- Counter read:
  - req = 1 at t gives valid = 1 and contador = count[idx] at t+1. The value is the count as of cycle t, before any push counted at t+1.
  - req = 0 gives valid = 0 and contador = 0.
  - In INIT, valid = 0.

Test Plan:
- Reset with cmd_valid = 1 and req = 1 -> all outputs 0, cmd_ready = 0. Release reset, pulse init, drop init -> cmd_ready = 1.
- Command port 2, dest 3, len 4, seed 0xFE -> push_out2 for 4 consecutive cycles starting 1 cycle after accept. data_out2 = 0x3FE, 0x3FF, 0x300, 0x301; busy[2] = 0 after the last push; req with idx = 2 -> valid = 1, contador = 4.
- Port 0, len 6, almost_full0 = 1 for cycles 2-4 after accept -> exactly 6 pushes; the pause starts 1 cycle after almost_full0 rises; data_out0 is held during the stall; payload sequence is gapless.
- Commands to ports 0, 1, 3 on consecutive cycles, len 15 each -> all three push concurrently. A second command to port 1 while busy -> cmd_ready = 0 until busy[1] clears.
- Raise init mid-burst (port 1, 3 words sent) -> push_out1 = 0 next cycle, busy = 0, a counter read after init falls returns 0; a len = 0 command -> accepted, no push. Three bursts of len 15 to one port (45 pushes) -> contador = 31 (saturated).

Source files
------------

// File: rtl/tlp_tx_source_if.sv
`default_nettype none
// ============================================================================
// Module  : tlp_tx_source_if
// Brief   : Command, ingress-FIFO push and counter-readout bundle for the
//           transaction-layer TX traffic source.
// Revision: 1.0  initial release
// ============================================================================
interface tlp_tx_source_if #(
  parameter int DW = 10,
  parameter int LW = 4,
  parameter int CW = 5
);
  // Control and burst command channel
  logic                  init;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_port;
  logic [1:0]            cmd_dest;
  logic [LW-1:0]         cmd_len;
  logic [7:0]            cmd_seed;

  // Ingress FIFO side, bit/element i belongs to FIFO i
  logic [3:0]            almost_full;
  logic [3:0]            push_out;
  logic [3:0][DW-1:0]    data_out;
  logic [3:0]            busy;

  // Sent-word counter readout
  logic                  req;
  logic [1:0]            idx;
  logic [CW-1:0]         contador;
  logic                  valid;

  modport master (
    output init, cmd_valid, cmd_port, cmd_dest, cmd_len, cmd_seed,
    output almost_full, req, idx,
    input  cmd_ready, push_out, data_out, busy, contador, valid
  );

  modport slave (
    input  init, cmd_valid, cmd_port, cmd_dest, cmd_len, cmd_seed,
    input  almost_full, req, idx,
    output cmd_ready, push_out, data_out, busy, contador, valid
  );
endinterface
`default_nettype wire

// File: rtl/tlp_tx_source.sv
`default_nettype none
// ============================================================================
// Module  : tlp_tx_source
// Brief   : Four independent burst engines feeding the PCIe ingress FIFOs,
//           with almost_full backpressure and saturating sent-word counters.
// Revision: 1.0  initial release
// ============================================================================
module tlp_tx_source #(
  parameter int DW = 10,
  parameter int LW = 4,
  parameter int CW = 5
) (
  input  logic            clk,
  input  logic            reset,
  tlp_tx_source_if.slave  bus
);

  localparam int            c_nport   = 4;
  localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t               state_q;
  logic                 valid_q;
  logic [CW-1:0]        contador_q;

  logic                 w_run;
  logic                 w_clear;
  logic                 w_accept;
  logic [c_nport-1:0]   w_busy;
  logic [c_nport-1:0]   w_busy_nx;
  logic [CW-1:0]        w_cnt [c_nport];

  // Engines only run in IDLE/ACTIVE; raising init there aborts on the same edge.
  assign w_run    = (state_q == S_IDLE) || (state_q == S_ACTIVE);
  assign w_clear  = !w_run || bus.init;

  // Sole combinational output: decoded from registered state and busy.
  assign bus.cmd_ready = w_run && !w_busy[bus.cmd_port];
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign bus.busy      = w_busy;

  for (genvar gi = 0; gi < c_nport; gi++) begin : g_engine
    logic             busy_q, busy_d;
    logic             push_q, push_d;
    logic [LW-1:0]    rem_q,  rem_d;
    logic [7:0]       pay_q,  pay_d;
    logic [1:0]       dst_q,  dst_d;
    logic [DW-1:0]    data_q, data_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             w_load;

    // Zero-length commands are accepted but never load the engine.
    assign w_load = w_accept && (bus.cmd_port == 2'(gi)) && (bus.cmd_len != '0);

    // Next-state: the accepted command already pushes its first word on the
    // accept edge, so the first push is visible one cycle after acceptance.
    always_comb begin
      busy_d = busy_q;
      push_d = 1'b0;
      rem_d  = rem_q;
      pay_d  = pay_q;
      dst_d  = dst_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (w_clear) begin
        busy_d = 1'b0;
        rem_d  = '0;
        pay_d  = '0;
        dst_d  = '0;
        data_d = '0;
        cnt_d  = '0;
      end else begin
        if (w_load) begin
          dst_d = bus.cmd_dest;
          if (bus.almost_full[gi]) begin
            busy_d = 1'b1;
            rem_d  = bus.cmd_len;
            pay_d  = bus.cmd_seed;
          end else begin
            push_d = 1'b1;
            data_d = DW'({bus.cmd_dest, bus.cmd_seed});
            pay_d  = bus.cmd_seed + 8'd1;
            rem_d  = bus.cmd_len - LW'(1);
            busy_d = (bus.cmd_len != LW'(1));
          end
        end else if (busy_q && !bus.almost_full[gi]) begin
          push_d = 1'b1;
          data_d = DW'({dst_q, pay_q});
          pay_d  = pay_q + 8'd1;
          rem_d  = rem_q - LW'(1);
          busy_d = (rem_q != LW'(1));
        end
        // Count the push on the edge that raises push_out, saturating.
        if (push_d && (cnt_q != c_cnt_max)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // Engine and counter registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        busy_q <= 1'b0;
        push_q <= 1'b0;
        rem_q  <= '0;
        pay_q  <= '0;
        dst_q  <= '0;
        data_q <= '0;
        cnt_q  <= '0;
      end else begin
        busy_q <= busy_d;
        push_q <= push_d;
        rem_q  <= rem_d;
        pay_q  <= pay_d;
        dst_q  <= dst_d;
        data_q <= data_d;
        cnt_q  <= cnt_d;
      end
    end

    assign w_busy[gi]       = busy_q;
    assign w_busy_nx[gi]    = busy_d;
    assign bus.push_out[gi] = push_q;
    assign bus.data_out[gi] = data_q;
    assign w_cnt[gi]        = cnt_q;
  end

  // Global FSM: RESET -> INIT -> IDLE/ACTIVE, with init pulling back to INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_INIT;
        S_INIT:  state_q <= bus.init ? S_INIT : S_IDLE;
        default: begin
          if (bus.init) begin
            state_q <= S_INIT;
          end else if (w_busy_nx != '0) begin
            state_q <= S_ACTIVE;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Counter readout: registered snapshot of the selected counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      contador_q <= '0;
    end else if (w_run && bus.req) begin
      valid_q    <= 1'b1;
      contador_q <= w_cnt[bus.idx];
    end else begin
      valid_q    <= 1'b0;
      contador_q <= '0;
    end
  end

  assign bus.valid    = valid_q;
  assign bus.contador = contador_q;

endmodule
`default_nettype wire
